// File: rtl/rv32_pkg.sv
// Shared RV32 core types used by the hazard scoreboard.
package rv32_pkg;
  localparam int REG_IDX_W = 5;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [2:0] sb_lat_t;
  localparam sb_lat_t SB_LAT_VAR = '0;
endpackage

// File: rtl/rv32_sb_entry.sv
// One scoreboard slot: busy bit, fixed-latency down-counter and variable-latency flag.
module rv32_sb_entry
  import rv32_pkg::*;
#(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic [LAT_W-1:0] set_lat,
  input  logic             tick,
  input  logic             wb_hit,
  input  logic             flush,
  output logic             busy,
  output logic             is_var
);

  logic             busy_q, busy_d;
  logic             var_q, var_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    busy_d = busy_q;
    var_d  = var_q;
    cnt_d  = cnt_q;
    if (flush) begin
      busy_d = 1'b0;
      var_d  = 1'b0;
      cnt_d  = '0;
    end else if (set) begin
      busy_d = 1'b1;
      var_d  = (set_lat == LAT_W'(SB_LAT_VAR));
      cnt_d  = set_lat;
    end else if (wb_hit) begin
      busy_d = 1'b0;
      var_d  = 1'b0;
    end else if (tick && cnt_q != '0) begin
      // counter stops at zero, so it can never wrap
      cnt_d = cnt_q - LAT_W'(1);
      if (cnt_q == LAT_W'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      var_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      var_q  <= var_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy   = busy_q;
  assign is_var = var_q;

endmodule

// File: rtl/rv32_hazard_scoreboard.sv
// Per-register RAW/WAW hazard scoreboard gating ID issue.
// Optional performance counters enabled by SCOREBOARD_PERF_EN.
module rv32_hazard_scoreboard
  import rv32_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 3,
  parameter int REG_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [REG_W-1:0]    issue_rs1,
  input  logic [REG_W-1:0]    issue_rs2,
  input  logic [1:0]          issue_rs_used,
  input  logic                issue_we,
  input  logic [REG_W-1:0]    issue_rd,
  input  logic [LAT_W-1:0]    issue_lat,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd,
  input  logic                flush,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [REG_W:0]      pending_cnt,
`ifdef SCOREBOARD_PERF_EN
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_raw,
  output logic [31:0]         perf_waw,
`endif
  output logic                wb_err
);

  localparam int IDX_N = 2 ** REG_W;

  logic [NUM_REGS-1:0] busy, is_var;
  logic [NUM_REGS-1:1] set_vec, wb_hit_vec;
  logic [IDX_N-1:0]    busy_x, var_x;
  logic                raw, waw, accept;
  logic                wb_err_q, wb_err_d;

  assign busy[0]   = 1'b0;
  assign is_var[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    assign set_vec[i]    = accept & issue_we & (issue_rd == REG_W'(i));
    assign wb_hit_vec[i] = wb_valid & (wb_rd == REG_W'(i)) & busy[i] & is_var[i];
    rv32_sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk     (clk),
      .rst_n   (rst_n),
      .set     (set_vec[i]),
      .set_lat (issue_lat),
      .tick    (1'b1),
      .wb_hit  (wb_hit_vec[i]),
      .flush   (flush),
      .busy    (busy[i]),
      .is_var  (is_var[i])
    );
  end

  // widen to the full index space so any index value is a safe lookup
  always_comb begin
    busy_x                = '0;
    var_x                 = '0;
    busy_x[NUM_REGS-1:0]  = busy;
    var_x[NUM_REGS-1:0]   = is_var;
  end

  assign raw         = (issue_rs_used[0] & busy_x[issue_rs1]) | (issue_rs_used[1] & busy_x[issue_rs2]);
  assign waw         = issue_we & busy_x[issue_rd];
  assign issue_ready = ~(raw | waw) & ~flush;
  assign stall       = issue_valid & ~issue_ready;
  assign accept      = issue_valid & issue_ready;

  assign wb_err_d = wb_valid & ~(busy_x[wb_rd] & var_x[wb_rd]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_err_q <= 1'b0;
    else        wb_err_q <= wb_err_d;
  end

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) pending_cnt = pending_cnt + (REG_W+1)'(busy[i]);
  end

  assign busy_mask = busy;
  assign wb_err    = wb_err_q;

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_raw_q, perf_raw_d;
  logic [31:0] perf_waw_q, perf_waw_d;
  logic        stall_cnt_en;

  assign stall_cnt_en = stall & ~flush;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_raw_d   = perf_raw_q;
    perf_waw_d   = perf_waw_q;
    if (stall_cnt_en && perf_stall_q != '1)      perf_stall_d = perf_stall_q + 32'd1;
    if (stall_cnt_en && raw && perf_raw_q != '1) perf_raw_d   = perf_raw_q + 32'd1;
    if (stall_cnt_en && waw && perf_waw_q != '1) perf_waw_d   = perf_waw_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_raw_q   <= '0;
      perf_waw_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_raw_q   <= perf_raw_d;
      perf_waw_q   <= perf_waw_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_raw          = perf_raw_q;
  assign perf_waw          = perf_waw_q;
`endif

endmodule

// File: tb/tb_rv32_hazard_scoreboard.sv
// Self-checking bench for rv32_hazard_scoreboard: directed table, randomized run vs. reference model.
module tb_rv32_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready, issue_we, wb_valid, flush, stall, wb_err;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic [1:0]  issue_rs_used;
  logic [2:0]  issue_lat;
  logic [31:0] busy_mask;
  logic [5:0]  pending_cnt;
`ifdef SCOREBOARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_raw, perf_waw;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  rv32_hazard_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_rs_used (issue_rs_used),
    .issue_we      (issue_we),
    .issue_rd      (issue_rd),
    .issue_lat     (issue_lat),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .flush         (flush),
    .stall         (stall),
    .busy_mask     (busy_mask),
    .pending_cnt   (pending_cnt),
`ifdef SCOREBOARD_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_raw          (perf_raw),
    .perf_waw          (perf_waw),
`endif
    .wb_err        (wb_err)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs1, rs2;
    logic [1:0] used;
    logic       we;
    logic [4:0] rd;
    logic [2:0] lat;
    logic       wbv;
    logic [4:0] wbrd;
    logic       fl;
    logic       exp_ready;
    logic [5:0] exp_pend;
    logic       exp_err;
  } vec_t;

  // Reference model: a set of pending writes, each with cycles remaining (0 = awaiting writeback).
  bit m_busy[32];
  int m_rem[32];
  bit m_err;
  int m_ps, m_pr, m_pw;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_rem[i] = 0; end
    m_err = 0; m_ps = 0; m_pr = 0; m_pw = 0;
  endfunction

  function automatic bit m_raw(vec_t v);
    return (v.used[0] && m_busy[v.rs1]) || (v.used[1] && m_busy[v.rs2]);
  endfunction

  function automatic bit m_waw(vec_t v);
    return v.we && m_busy[v.rd];
  endfunction

  function automatic bit m_ready(vec_t v);
    return !(m_raw(v) || m_waw(v)) && !v.fl;
  endfunction

  function automatic void m_update(vec_t v);
    bit rdy = m_ready(v);
    bit err_n = v.wbv && !(m_busy[v.wbrd] && m_rem[v.wbrd] == 0);
    bit hit = v.wbv && v.wbrd != 0 && m_busy[v.wbrd] && m_rem[v.wbrd] == 0;
    if (v.valid && !rdy && !v.fl) begin
      m_ps++;
      if (m_raw(v)) m_pr++;
      if (m_waw(v)) m_pw++;
    end
    if (v.fl) begin
      for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_rem[i] = 0; end
    end else begin
      for (int i = 1; i < 32; i++)
        if (m_busy[i] && m_rem[i] > 0) begin
          m_rem[i]--;
          if (m_rem[i] == 0) m_busy[i] = 0;
        end
      if (hit) m_busy[v.wbrd] = 0;
      if (v.valid && rdy && v.we && v.rd != 0) begin
        m_busy[v.rd] = 1;
        m_rem[v.rd]  = int'(v.lat);
      end
    end
    m_err = err_n;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < 32; i++) m[i] = m_busy[i];
    return m;
  endfunction

  function automatic int m_pend();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic valid, logic [4:0] rs1, logic [4:0] rs2, logic [1:0] used,
                              logic we, logic [4:0] rd, logic [2:0] lat, logic wbv, logic [4:0] wbrd,
                              logic fl, logic er, logic [5:0] ep, logic ee);
    vec_t v;
    v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.used = used; v.we = we; v.rd = rd;
    v.lat = lat; v.wbv = wbv; v.wbrd = wbrd; v.fl = fl;
    v.exp_ready = er; v.exp_pend = ep; v.exp_err = ee;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    issue_valid = v.valid; issue_rs1 = v.rs1; issue_rs2 = v.rs2; issue_rs_used = v.used;
    issue_we = v.we; issue_rd = v.rd; issue_lat = v.lat;
    wb_valid = v.wbv; wb_rd = v.wbrd; flush = v.fl;
  endtask

  task automatic cyc(input vec_t v, input bit tab, input string tag);
    logic exp_ready;
    drive(v);
    @(negedge clk);
    exp_ready = m_ready(v);
    check({tag, " issue_ready"}, 32'(issue_ready), 32'(exp_ready));
    check({tag, " stall"}, 32'(stall), 32'(v.valid && !exp_ready));
    check({tag, " busy_mask"}, busy_mask, m_mask());
    check({tag, " pending_cnt"}, 32'(pending_cnt), 32'(m_pend()));
    check({tag, " wb_err"}, 32'(wb_err), 32'(m_err));
`ifdef SCOREBOARD_PERF_EN
    check({tag, " perf_stall"}, perf_stall_cycles, 32'(m_ps));
    check({tag, " perf_raw"}, perf_raw, 32'(m_pr));
    check({tag, " perf_waw"}, perf_waw, 32'(m_pw));
`endif
    if (tab) begin
      check({tag, " tab_ready"}, 32'(issue_ready), 32'(v.exp_ready));
      check({tag, " tab_pending"}, 32'(pending_cnt), 32'(v.exp_pend));
      check({tag, " tab_wb_err"}, 32'(wb_err), 32'(v.exp_err));
    end
    @(posedge clk);
    m_update(v);
    #1;
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
  endtask

  vec_t tab[20];
  vec_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    //            val rs1 rs2 used we rd lat wbv wbrd fl  rdy pend err
    tab[0]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,   1, 0, 0);
    tab[1]  = mk(1, 0, 0, 2'b00, 1, 9, 3, 0, 0, 0,   1, 0, 0);
    tab[2]  = mk(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0,   0, 1, 0);
    tab[3]  = mk(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0,   0, 1, 0);
    tab[4]  = mk(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0,   0, 1, 0);
    tab[5]  = mk(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0,   1, 0, 0);
    tab[6]  = mk(1, 0, 0, 2'b00, 1, 8, 0, 0, 0, 0,   1, 0, 0);
    tab[7]  = mk(1, 0, 0, 2'b00, 1, 8, 2, 0, 0, 0,   0, 1, 0);
    tab[8]  = mk(1, 0, 0, 2'b00, 1, 8, 2, 1, 8, 0,   0, 1, 0);
    tab[9]  = mk(1, 0, 0, 2'b00, 1, 8, 2, 0, 0, 0,   1, 0, 0);
    tab[10] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,   1, 1, 0);
    tab[11] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,   1, 1, 0);
    tab[12] = mk(1, 0, 0, 2'b00, 1, 5, 0, 0, 0, 0,   1, 0, 0);
    tab[13] = mk(1, 0, 0, 2'b11, 1, 0, 1, 0, 0, 0,   1, 1, 0);
    tab[14] = mk(1, 0, 0, 2'b00, 1, 6, 5, 0, 0, 0,   1, 1, 0);
    tab[15] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1,   0, 2, 0);
    tab[16] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,   1, 0, 0);
    tab[17] = mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 5, 0,   1, 0, 0);
    tab[18] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,   1, 0, 1);
    tab[19] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,   1, 0, 0);

    do_reset();
    for (int i = 0; i < 20; i++) cyc(tab[i], 1'b1, $sformatf("tab%0d", i));

    for (int n = 0; n < 1500; n++) begin
      vec_t v;
      v = mk(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             2'($urandom), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 49) == 0), 0, 0, 0);
      cyc(v, 1'b0, "rand");
    end

    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b0, "pre_rst_flush");
    cyc(mk(1, 0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 0, 0), 1'b0, "pre_rst_issue");
    drive(idle);
    @(negedge clk);
    check("pre_rst busy7", 32'(busy_mask[7]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst busy_mask", busy_mask, 32'd0);
    check("async_rst pending", 32'(pending_cnt), 32'd0);
    check("async_rst wb_err", 32'(wb_err), 32'd0);
    check("async_rst ready", 32'(issue_ready), 32'd1);
    #1 rst_n = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    cyc(idle, 1'b0, "post_rst");

    do_reset();
    cyc(mk(1, 0, 0, 2'b00, 1, 3, 4, 0, 0, 0, 1, 0, 0), 1'b0, "perf_prod");
    for (int i = 0; i < 5; i++) cyc(mk(1, 3, 0, 2'b01, 1, 4, 2, 0, 0, 0, 0, 0, 0), 1'b0, "perf_raw");
    for (int i = 0; i < 3; i++) cyc(mk(1, 0, 0, 2'b00, 1, 4, 1, 0, 0, 0, 0, 0, 0), 1'b0, "perf_waw");
    cyc(idle, 1'b0, "perf_idle");
`ifdef SCOREBOARD_PERF_EN
    check("perf_total stall", perf_stall_cycles, 32'd6);
    check("perf_total raw", perf_raw, 32'd4);
    check("perf_total waw", perf_waw, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32_hazard_scoreboard.md
Name: rv32_hazard_scoreboard

Overview:
- Per-register RAW/WAW hazard scoreboard for the RV32I pipeline core; replaces the fixed load-use stall check in ID.
- Each in-flight write is either fixed-latency (an internal countdown clears it) or variable-latency (a writeback strobe from a multi-cycle unit such as a data memory or divider clears it).
- The issue stage in ID handshakes with this block; the block gates instruction issue.

Parameters:
- NUM_REGS, 32, number of architectural registers; index 0 is hard-wired zero and never busy.
- LAT_W, 3, width of the latency field; fixed latency range is 1..2^LAT_W-1.
- REG_W, 5, register index width; must satisfy 2^REG_W >= NUM_REGS.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  ID presents an instruction.
- issue_ready  out  1  the instruction may issue this cycle; combinational.
- issue_rs1  in  REG_W  source 1 index.
- issue_rs2  in  REG_W  source 2 index.
- issue_rs_used  in  2  bit0 means rs1 is read, bit1 means rs2 is read.
- issue_we  in  1  the instruction writes issue_rd.
- issue_rd  in  REG_W  destination index.
- issue_lat  in  LAT_W  cycles until the result is in the regfile; 0 means variable latency.
- wb_valid  in  1  variable-latency completion strobe.
- wb_rd  in  REG_W  completing register.
- flush  in  1  kill all pending entries (branch/jump redirect).
- stall  out  1  issue_valid & ~issue_ready.
- busy_mask  out  NUM_REGS  registered busy bits; bit0 is always 0.
- pending_cnt  out  REG_W+1  popcount of busy_mask.
- wb_err  out  1  registered one-cycle pulse on a spurious writeback.

Behaviour:
- Reset: all busy bits, counters and var flags are 0.
  - busy_mask=0, pending_cnt=0, wb_err=0, issue_ready=1.
- Per entry i (1..NUM_REGS-1): busy bit, LAT_W counter, var flag.
- Hazard (combinational, from registered state):
  - RAW: (rs_used[0] & busy[rs1]) | (rs_used[1] & busy[rs2]).
  - WAW: issue_we & busy[rd].
  - issue_ready = ~(RAW | WAW) & ~flush.
  - Any index equal to 0 never hazards.
- Accept = issue_valid & issue_ready.
  - If accepted with issue_we and rd!=0: busy[rd]<=1 at the next edge.
  - If issue_lat!=0: cnt<=issue_lat, var<=0.
  - If issue_lat==0: var<=1.
- Fixed-latency entry: cnt decrements each cycle; at the edge where cnt goes 1->0, busy clears.
  - A dependent instruction therefore stalls exactly issue_lat cycles after the producer.
- Variable-latency entry: holds busy until wb_valid with wb_rd==i and var==1; busy clears at that edge.
- wb_valid to an entry that is not busy, not var, or has wb_rd==0:
  - No state change.
  - wb_err=1 for the next cycle.
- Simultaneous set and clear of the same entry: cannot occur, because WAW blocks the issue. A simultaneous clear of entry A with an issue to entry B is independent.
- flush: at the next edge, all busy/var/cnt clear.
  - flush has priority over accept and over wb.
  - A later wb to a flushed entry raises wb_err.
- busy_mask and pending_cnt reflect registered state only, with no same-cycle bypass.
- Counter wrap: impossible, because counters load only nonzero values and stop at 0.
- Reset mid-operation: all state clears immediately (asynchronous); outputs return to reset values.

Optional Feature:
- SCOREBOARD_PERF_EN defined:
  - Adds outputs perf_stall_cycles[31:0], perf_raw[31:0] and perf_waw[31:0].
  - perf_stall_cycles increments every cycle stall=1 and flush=0.
  - perf_raw and perf_waw increment on stall cycles whose cause includes RAW or WAW, respectively.
  - Counters saturate at 0xFFFFFFFF; reset clears them; flush does not.
- Undefined: these ports and counters do not exist.

Decomposition:
- rv32_pkg additions:
  - REG_IDX_W = 5.
  - typedef reg_idx_t = logic [REG_IDX_W-1:0].
  - typedef sb_lat_t = logic [2:0].
  - localparam SB_LAT_VAR = '0.
- Sub-module rv32_sb_entry: one busy/var/cnt slot with set, tick, wb_hit and flush inputs and a busy output.
  - Generated for indices 1..NUM_REGS-1.
  - The top level holds the hazard compare, popcount, wb_err and perf logic.

Test Plan:
- Reset, then an idle cycle -> busy_mask=0, pending_cnt=0, issue_ready=1, wb_err=0.
- Issue rd=x9, lat=3, then hold issue of rs1=x9 -> stall=1 for exactly 3 cycles, then issue_ready=1; busy_mask[9] clears after the third cycle.
- Issue rd=x8, lat=0 (load), then issue rd=x8 (WAW) -> stalls until wb_valid with wb_rd=8; accepted on the cycle after the wb edge.
- Issue rs2=x0, rd=x0, rs_used=2'b11 with x5 busy elsewhere -> issue_ready=1, and busy_mask[0] stays 0.
- Busy x5 (lat 0) and x6 (lat 5), then flush -> busy_mask=0 next cycle; a later wb_rd=5 -> wb_err pulses exactly 1 cycle.
- With SCOREBOARD_PERF_EN: a 4-cycle RAW stall followed by a 2-cycle WAW stall -> perf_stall_cycles=6, perf_raw=4, perf_waw=2.
